// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// even-parity rule used by both the RX and TX stages.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_RATE  = 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Even parity: data plus parity bit must hold an even number of ones.
  // Data is zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity_err(input logic [31:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Lower clamp on the programmed bit period so the half-bit is never zero.
  function automatic logic [31:0] clamp_rate(input logic [31:0] rate, input logic [31:0] min_rate);
    logic [31:0] res;
    if (rate < min_rate) begin
      res = min_rate;
    end else begin
      res = rate;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling, even parity and stop
// check, with a sticky byte-ready flag and a sticky framing-error flag.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = uart_pkg::DATA_BITS,
  parameter int MIN_RATE  = uart_pkg::MIN_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [31:0]          byte_rate,
  input  logic                 rx_flag_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity,
  output logic                 parity_err,
  output logic                 rx_flag,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_fall;
  logic [31:0]          w_br;

  logic                 r_rxs_d;
  rx_state_e            r_state;
  logic [31:0]          r_cnt;
  logic [31:0]          r_br;
  logic [31:0]          r_half;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_parity;
  logic                 r_parity_err;
  logic                 r_rx_flag;
  logic                 r_frame_err;
  logic                 r_busy;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rxs)
  );

  assign w_fall = r_rxs_d & ~w_rxs;
  assign w_br   = clamp_rate(byte_rate, 32'(MIN_RATE));

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxs_d <= 1'b1;
    end else begin
      r_rxs_d <= w_rxs;
    end
  end

  // Receive FSM; flag clears are written first so a same-cycle set overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 32'd0;
      r_br         <= 32'd0;
      r_half       <= 32'd0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_rx_data    <= '0;
      r_parity     <= 1'b0;
      r_parity_err <= 1'b0;
      r_rx_flag    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (rx_flag_clr) begin
        r_rx_flag   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_cnt   <= 32'd0;
            r_br    <= w_br;
            r_half  <= w_br >> 1;
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == r_half - 32'd1) begin
            r_cnt <= 32'd0;
            if (w_rxs == START_BIT) begin
              r_idx   <= '0;
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        DATA: begin
          if (r_cnt == r_br - 32'd1) begin
            r_cnt          <= 32'd0;
            r_shift[r_idx] <= w_rxs;
            if (r_idx == LAST_IDX) begin
              r_state <= PARITY;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        PARITY: begin
          if (r_cnt == r_br - 32'd1) begin
            r_cnt   <= 32'd0;
            r_par   <= w_rxs;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        STOP: begin
          if (r_cnt == r_br - 32'd1) begin
            r_cnt <= 32'd0;
            if (w_rxs == STOP_BIT) begin
              r_rx_data    <= r_shift;
              r_parity     <= r_par;
              r_parity_err <= even_parity_err(32'(r_shift), r_par);
              r_rx_flag    <= 1'b1;
              r_frame_err  <= 1'b0;
              r_state      <= IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        BREAK: begin
          // A line held low must return high before a new start can be seen.
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign parity     = r_parity;
  assign parity_err = r_parity_err;
  assign rx_flag    = r_rx_flag;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: serial frames are driven on the falling
// clock edge and outputs are compared on the falling edge against fixed values.
module tb_uart_rx_frame;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] byte_rate;
  logic        rx_flag_clr;
  logic [7:0]  rx_data;
  logic        parity;
  logic        parity_err;
  logic        rx_flag;
  logic        frame_err;
  logic        busy;

  int n_checks;
  int n_errors;

  uart_rx_frame dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .byte_rate   (byte_rate),
    .rx_flag_clr (rx_flag_clr),
    .rx_data     (rx_data),
    .parity      (parity),
    .parity_err  (parity_err),
    .rx_flag     (rx_flag),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start, 8 data bits LSB first, parity and stop; the line is left at the stop value.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stp, input int rate);
    logic [10:0] bits;
    bits = {stp, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx = bits[i];
      repeat (rate - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    rx          = 1'b1;
    byte_rate   = 32'd16;
    rx_flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_parity", {31'd0, parity}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_flag", {31'd0, rx_flag}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(4);

    // Good frame 0xA5; stop sample lands on the 171st rising edge after rx falls.
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 16);
      begin
        @(negedge clk);
        repeat (170) @(posedge clk);
        @(negedge clk);
        check("a5_flag_before", {31'd0, rx_flag}, 32'd0);
        check("a5_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("a5_flag", {31'd0, rx_flag}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_busy", {31'd0, busy}, 32'd0);
      end
    join
    idle(10);
    check("a5_perr", {31'd0, parity_err}, 32'd0);

    // Parity fault: 0x01 has odd weight, parity bit 0.
    send_frame(8'h01, 1'b0, 1'b1, 16);
    idle(10);
    check("pf_data", {24'd0, rx_data}, 32'h01);
    check("pf_perr", {31'd0, parity_err}, 32'd1);
    check("pf_parity", {31'd0, parity}, 32'd0);
    check("pf_flag", {31'd0, rx_flag}, 32'd1);

    // Start glitch: 4 low cycles, shorter than the half-bit of 8.
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("gl_busy_mid", {31'd0, busy}, 32'd1);
    idle(20);
    check("gl_busy", {31'd0, busy}, 32'd0);
    check("gl_data", {24'd0, rx_data}, 32'h01);
    check("gl_flag", {31'd0, rx_flag}, 32'd1);
    check("gl_ferr", {31'd0, frame_err}, 32'd0);
    check("gl_perr", {31'd0, parity_err}, 32'd1);

    // Framing error with the line held low afterwards.
    send_frame(8'h3C, 1'b0, 1'b0, 16);
    repeat (40) @(negedge clk);
    check("fe_ferr", {31'd0, frame_err}, 32'd1);
    check("fe_data", {24'd0, rx_data}, 32'h01);
    check("fe_flag", {31'd0, rx_flag}, 32'd1);
    check("fe_busy_low", {31'd0, busy}, 32'd1);
    idle(20);
    check("fe_busy_rel", {31'd0, busy}, 32'd0);
    check("fe_ferr_rel", {31'd0, frame_err}, 32'd1);

    // Recovery frame clears the framing error.
    send_frame(8'h3C, 1'b0, 1'b1, 16);
    idle(10);
    check("rc_data", {24'd0, rx_data}, 32'h3C);
    check("rc_ferr", {31'd0, frame_err}, 32'd0);
    check("rc_perr", {31'd0, parity_err}, 32'd0);

    // Plain clear, then clear coinciding with the stop-sample edge.
    rx_flag_clr = 1'b1;
    @(negedge clk);
    rx_flag_clr = 1'b0;
    check("clr_flag", {31'd0, rx_flag}, 32'd0);
    fork
      send_frame(8'h81, 1'b0, 1'b1, 16);
      begin
        @(negedge clk);
        repeat (170) @(posedge clk);
        @(negedge clk);
        check("race_flag_before", {31'd0, rx_flag}, 32'd0);
        rx_flag_clr = 1'b1;
        @(negedge clk);
        check("race_flag_set", {31'd0, rx_flag}, 32'd1);
        check("race_data", {24'd0, rx_data}, 32'h81);
        @(negedge clk);
        check("race_flag_clr", {31'd0, rx_flag}, 32'd0);
        rx_flag_clr = 1'b0;
      end
    join
    idle(10);

    // Reset during data bit 4; the frame's tail stays high so nothing restarts.
    fork
      send_frame(8'hF0, 1'b1, 1'b1, 16);
      begin
        @(negedge clk);
        repeat (85) @(posedge clk);
        @(negedge clk);
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_data", {24'd0, rx_data}, 32'h00);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_flag", {31'd0, rx_flag}, 32'd0);
        check("mr_perr", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
      end
    join
    idle(20);
    check("mr_flag_after", {31'd0, rx_flag}, 32'd0);

    // byte_rate 1 is clamped to 2.
    byte_rate = 32'd1;
    send_frame(8'h5A, 1'b0, 1'b1, 2);
    idle(10);
    check("slow_data", {24'd0, rx_data}, 32'h5A);
    check("slow_flag", {31'd0, rx_flag}, 32'd1);
    check("slow_perr", {31'd0, parity_err}, 32'd0);

    // Rate change mid-frame only affects later frames.
    byte_rate = 32'd16;
    idle(4);
    fork
      send_frame(8'hC3, 1'b0, 1'b1, 16);
      begin
        repeat (41) @(negedge clk);
        byte_rate = 32'd32;
      end
    join
    idle(10);
    check("rate_data", {24'd0, rx_data}, 32'hC3);
    check("rate_ferr", {31'd0, frame_err}, 32'd0);
    check("rate_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
